// File: rtl/macram_reader.sv
// macram_reader: dumps every MAC bank channel to a ready/valid stream; CLEAR phase built when MACRAM_READER_CLEAR_EN is defined
module macram_reader #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int GUARD = 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              hold,
  output logic              mac_read,
  output logic [ADDR_W-1:0] mac_rAddr,
  input  logic [DATA_W-1:0] mac_rData,
  output logic              mac_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);
  typedef enum logic [2:0] {IDLE, HOLD, ENTER, ISSUE, DRAIN, CLEAR, DONE} state_t;
  localparam int EW = DATA_W + ADDR_W;
  localparam logic [ADDR_W-1:0] LAST = '1;
  state_t state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, idx1_q, idx1_d, idx2_q, idx2_d;
  logic v1_q, v1_d, v2_q, v2_d;
  logic [3:0][EW-1:0] mem_q, mem_d;
  logic [1:0] rd_q, rd_d, wr_q, wr_d;
  logic [2:0] fill_q, fill_d;
  logic [EW-1:0] head;
  logic issue, pop;
  always_comb begin
    head = mem_q[rd_q];
    out_valid = fill_q != 3'd0;
    out_data = out_valid ? head[EW-1:ADDR_W] : '0;
    out_index = out_valid ? head[ADDR_W-1:0] : '0;
    out_last = out_valid && head[ADDR_W-1:0] == LAST;
    pop = out_valid && out_ready;
    issue = state_q == ISSUE && fill_q + 3'(v1_q) + 3'(v2_q) < 3'd4;
    busy = state_q != IDLE;
    hold = busy;
    done = state_q == DONE;
    mac_read = state_q == ENTER || state_q == ISSUE || (state_q == DRAIN && (v1_q || v2_q));
    mac_rAddr = addr_q;
`ifdef MACRAM_READER_CLEAR_EN
    mac_clr = state_q == CLEAR && cnt_q == 16'd1;
`else
    mac_clr = 1'b0;
`endif
    v1_d = issue;
    idx1_d = addr_q;
    v2_d = v1_q;
    idx2_d = idx1_q;
    mem_d = mem_q;
    if (v2_q) mem_d[wr_q] = {mac_rData, idx2_q};
    wr_d = wr_q + 2'(v2_q);
    rd_d = rd_q + 2'(pop);
    fill_d = fill_q + 3'(v2_q) - 3'(pop);
    addr_d = issue && addr_q != LAST ? addr_q + ADDR_W'(1) : addr_q;
    state_d = state_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: state_d = start ? HOLD : IDLE;
      HOLD: begin
        cnt_d = cnt_q == 16'(GUARD - 1) ? '0 : cnt_q + 16'd1;
        state_d = cnt_q == 16'(GUARD - 1) ? ENTER : HOLD;
      end
      ENTER: state_d = ISSUE;
      ISSUE: state_d = issue && addr_q == LAST ? DRAIN : ISSUE;
      DRAIN: if (!v1_q && !v2_q && fill_q == 3'd0) begin
`ifdef MACRAM_READER_CLEAR_EN
        state_d = CLEAR;
`else
        state_d = DONE;
`endif
      end
`ifdef MACRAM_READER_CLEAR_EN
      CLEAR: begin
        cnt_d = cnt_q == 16'(2**ADDR_W + 3) ? '0 : cnt_q + 16'd1;
        state_d = cnt_q == 16'(2**ADDR_W + 3) ? DONE : CLEAR;
      end
`endif
      DONE: begin
        state_d = IDLE;
        addr_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= '0;
      idx1_q <= '0;
      idx2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      mem_q <= '0;
      rd_q <= '0;
      wr_q <= '0;
      fill_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      idx1_q <= idx1_d;
      idx2_q <= idx2_d;
      v1_q <= v1_d;
      v2_q <= v2_d;
      mem_q <= mem_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: doc/macram_reader.md
MACRAM_READER -- requirements
Module: macram_reader

Interface
REQ-001 Parameter ADDR_W, default 5, meaning channel-address width (2**ADDR_W channels).
REQ-002 Parameter DATA_W, default 32, meaning accumulator word width.
REQ-003 Parameter GUARD, default 34, meaning cycles held off after hold assertion before first read.
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 start  input  1  one-cycle request to dump all channels; sampled only in IDLE.
REQ-007 busy  output  1  high in every state except IDLE.
REQ-008 done  output  1  one-cycle pulse when the dump (and clear, if built) is complete.
REQ-009 hold  output  1  to the sample generator: suppress sin to the MAC bank while high.
REQ-010 mac_read  output  1  read enable to the MAC bank.
REQ-011 mac_rAddr  output  ADDR_W  read address to the MAC bank.
REQ-012 mac_rData  input  DATA_W  read data from the MAC bank; valid 2 cycles after address.
REQ-013 mac_clr  output  1  clear request to the MAC bank (see Configuration).
REQ-014 out_valid  output  1  stream word valid.
REQ-015 out_ready  input  1  stream consumer ready; transfer when out_valid and out_ready are both high.
REQ-016 out_data  output  DATA_W  channel value.
REQ-017 out_index  output  ADDR_W  channel number of out_data.
REQ-018 out_last  output  1  high with the word for channel 2**ADDR_W-1.

Function
REQ-019 States: IDLE, HOLD, ENTER, ISSUE, DRAIN, CLEAR, DONE.
REQ-020 IDLE -> HOLD on start; hold rises on that edge; start ignored in every other state.
REQ-021 HOLD counts GUARD cycles with hold high, then -> ENTER, so that any in-progress 32-cycle MAC pass finishes.
REQ-022 ENTER lasts 1 cycle with mac_read=1 and mac_rAddr=0, letting the bank enter its read state; then -> ISSUE.
REQ-023 ISSUE keeps mac_read=1 and presents one address per cycle, from 0 up to 2**ADDR_W-1, with no skips or repeats.
REQ-024 Data for an address presented in cycle t is captured from mac_rData at the end of cycle t+2; tag it via a 2-stage valid/index pipeline.
REQ-025 An internal 4-entry output FIFO carries {data, index, last}; out_* come from the FIFO head (first-word fall-through).
REQ-026 Address advances only when free FIFO slots exceed in-flight pipeline entries; otherwise mac_rAddr holds and no new entry enters the pipeline.
REQ-027 The FIFO never overflows, and no word is dropped or duplicated under any out_ready pattern.
REQ-028 After the last address is issued -> DRAIN; mac_read stays 1 until the pipeline is empty, then drops.
REQ-029 DRAIN exits once the FIFO is empty and the last word has been transferred: to CLEAR (macro defined) or to DONE.
REQ-030 DONE lasts 1 cycle: done=1 and hold=0 on exit, then -> IDLE.
REQ-031 Simultaneous FIFO push and pop at any occupancy, including full and empty, is legal; occupancy is unchanged.
REQ-032 out_last is high only on index 2**ADDR_W-1.

Reset
REQ-033 On rst, from any state: -> IDLE, FIFO emptied, pipeline valids cleared, counters zeroed.
REQ-034 Reset values: busy, done, hold, mac_read, mac_clr, out_valid, out_last all 0; mac_rAddr, out_data, out_index all 0.
REQ-035 Reset mid-dump drops all pending words and emits no done.

Configuration
REQ-036 With macro MACRAM_READER_CLEAR_EN defined, CLEAR is built and runs as follows.
REQ-037 CLEAR, first cycle: mac_read=0, mac_clr=0 (bank returns to wait).
REQ-038 CLEAR, second cycle: mac_clr=1 for exactly one cycle.
REQ-039 CLEAR then waits 2**ADDR_W+2 cycles with hold high before -> DONE.
REQ-040 Without MACRAM_READER_CLEAR_EN, CLEAR is not built, mac_clr is constant 0, and DRAIN -> DONE.

Verification
REQ-041 Bank preloaded with ch[k]=k*3+1, out_ready=1, start pulse -> 32 words 1,4,...,94 with index 0..31, out_last only on 31, one done pulse.
REQ-042 Timing: start at cycle 0 -> hold=1 from cycle 1, first mac_read=1 at cycle 1+GUARD (35), mac_rAddr=0 then 0,1,2,...
REQ-043 out_ready toggled randomly 30% high -> same 32 words in order, FIFO count never >4, mac_rAddr stalls while the FIFO is full.
REQ-044 rst asserted at the transfer of index 10 -> next cycle all outputs at reset values, no done; new start -> full dump from index 0.
REQ-045 With MACRAM_READER_CLEAR_EN, after the dump -> single mac_clr pulse one cycle after mac_read falls; after done, a second dump returns all 0.
REQ-046 start held high through a whole dump -> exactly one dump and one done before returning to IDLE, then a second dump begins.
